mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between instruction fetch (IF) and data
//  load/store (D) requesters of the CPU core. Serialises accesses, gives data priority with
//  bounded fetch starvation, and aborts accesses the memory never acknowledges.
//  Sits between the core's fetch/load-store paths and the IOMemory-style backing store.
// PARAMETERS
//  AW               32  address width
//  DW               32  data width
//  MAX_DATA_STREAK  4   max consecutive D grants while IF waits (>=1)
//  TIMEOUT          16  cycles in BUSY without mem_ack before abort (>=1)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  if_req     in   1   fetch request; held until if_gnt
//  if_addr    in   AW  fetch address; stable while if_req & ~if_gnt
//  if_gnt     out  1   fetch request accepted this cycle
//  if_rvalid  out  1   one-cycle pulse: if_rdata/if_err valid
//  if_rdata   out  DW  fetched word
//  if_err     out  1   fetch aborted by timeout (with if_rvalid)
//  d_req      in   1   data request; held until d_gnt
//  d_we       in   1   1 = store, 0 = load; stable with d_req
//  d_addr     in   AW  data address; stable with d_req
//  d_wdata    in   DW  store data; stable with d_req
//  d_gnt      out  1   data request accepted this cycle
//  d_rvalid   out  1   one-cycle completion pulse (loads and stores)
//  d_rdata    out  DW  load data; 0 for stores and aborts
//  d_err      out  1   data access aborted by timeout (with d_rvalid)
//  mem_req    out  1   memory access in progress
//  mem_we     out  1   memory write enable (qualified by mem_req)
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_ack    in   1   memory completes access this cycle; mem_rdata valid
//  mem_rdata  in   DW  memory read data
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; all outputs 0; latched addr/we/wdata/rdata=0;
//   streak=0; wait counter=0. Reset mid-transaction drops mem_req at once, no rvalid issued.
//  FSM: IDLE -> BUSY (on grant) -> RESP (on mem_ack or timeout) -> IDLE (always, 1 cycle).
//  IDLE: gnt is combinational, only in IDLE. Selection:
//   - only one req: grant it.
//   - both: grant D unless streak==MAX_DATA_STREAK, then grant IF.
//   On grant edge: latch owner, addr, we (IF: we=0), wdata (IF: 0); wait counter=0.
//  Streak: D grant with if_req=1 -> streak+1 (saturating at MAX); D grant with if_req=0 -> 0;
//   IF grant -> 0.
//  BUSY: mem_req=1, mem_we/addr/wdata from latched values, stable for whole state.
//   mem_ack=1 -> latch mem_rdata (0 if we=1), err=0, go RESP.
//   else wait counter+1; counter==TIMEOUT-1 with no ack -> rdata=0, err=1, go RESP.
//   mem_ack and timeout same cycle: ack wins, err=0.
//  RESP: owner's rvalid=1 with rdata/err for exactly one cycle; other rvalid=0; no grants;
//   mem_req=0; then IDLE. mem_ack outside BUSY ignored.
//  Outside IDLE both gnt=0; pending reqs wait. Min latency: grant cycle T, ack at T+1,
//   rvalid at T+2; next grant earliest T+3.
//  rdata/err outputs 0 when corresponding rvalid=0.
// TESTING
//  1 IF only, addr 0x40, mem_ack 1 cycle after grant, rdata 0x2402000A -> if_gnt@T,
//    mem_req@T+1 addr 0x40 we 0, if_rvalid@T+2 rdata 0x2402000A, if_err 0.
//  2 Store d_addr 0x10 wdata 0xDEADBEEF, ack after 3 BUSY cycles -> mem_we=1 addr/wdata held
//    3 cycles, d_rvalid pulse with d_rdata 0, d_err 0; if_rvalid never set.
//  3 if_req and d_req held high continuously -> grant order D,D,D,D,IF,D,D,D,D,IF (MAX=4).
//  4 d_req load, mem_ack never asserted -> mem_req high exactly 16 cycles, then d_rvalid=1,
//    d_err=1, d_rdata=0; next pending IF granted the cycle after.
//  5 reset driven 0 in BUSY -> mem_req, busy fall same cycle; after release no rvalid, streak 0,
//    a later lone IF is granted in IDLE.
//  6 mem_ack pulsed in IDLE/RESP with no access -> no state change, no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch and
// data load/store requesters: data has priority, fetch starvation is bounded, hung accesses time out.
module mem_port_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e        state_q;
  logic          owner_d_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] streak_q;
  logic          grant_if;
  logic          grant_d;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == IDLE && reset) begin
      if (d_req && !(if_req && streak_q == STREAK_MAX)) grant_d = 1'b1;
      else if (if_req)                                   grant_if = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      streak_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_if || grant_d) begin
            state_q   <= BUSY;
            owner_d_q <= grant_d;
            we_q      <= grant_d & d_we;
            addr_q    <= grant_d ? d_addr : if_addr;
            wdata_q   <= grant_d ? d_wdata : '0;
            cnt_q     <= '0;
            if (grant_d && if_req)
              streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
            else
              streak_q <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rdata_q <= we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = (state_q == RESP) && !owner_d_q;
  assign d_rvalid  = (state_q == RESP) && owner_d_q;
  assign if_rdata  = if_rvalid ? rdata_q : '0;
  assign if_err    = if_rvalid & err_q;
  assign d_rdata   = d_rvalid ? rdata_q : '0;
  assign d_err     = d_rvalid & err_q;
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a cycle-level transaction model predicts
// grants, memory activity and responses; a separate monitor checks every response pulse.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 4, TO = 16;

  logic          clk = 1'b0, reset = 1'b0;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ack, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] rdata;
    bit            err;
    int            at;
  } resp_t;
  resp_t sb[$];

  int checks = 0, errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Requester and memory-side model state
  bit            if_pend = 0, d_pend = 0, dwe = 0;
  logic [AW-1:0] if_a = '0, d_a = '0;
  logic [DW-1:0] d_wd = '0;
  int            next_free = 0, busy_lo = -100, busy_hi = -100, ack_cyc = -1, streak_m = 0;
  logic [DW-1:0] ack_data = '0;
  bit            t_we = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wd = '0;

  task automatic step(input int rif, input int rd, input bit spur);
    bit in_busy, exp_if, exp_d, noack;
    int lat;
    resp_t r;
    @(posedge clk);
    #1;
    if (!if_pend && $urandom_range(99) < rif) begin if_pend = 1; if_a = $urandom; end
    if (!d_pend && $urandom_range(99) < rd) begin
      d_pend = 1; dwe = 1'($urandom_range(1)); d_a = $urandom; d_wd = $urandom;
    end
    if_req = if_pend; if_addr = if_a;
    d_req = d_pend; d_we = dwe; d_addr = d_a; d_wdata = d_wd;
    in_busy   = (cyc >= busy_lo) && (cyc <= busy_hi);
    mem_ack   = (cyc == ack_cyc) || (spur && !in_busy && ($urandom_range(3) == 0));
    mem_rdata = (cyc == ack_cyc) ? ack_data : DW'($urandom);
    @(negedge clk);
    check("mem_req", mem_req, in_busy);
    check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi + 1));
    if (in_busy) begin
      check("mem_we", mem_we, t_we);
      check("mem_addr", mem_addr, t_addr);
      check("mem_wdata", mem_wdata, t_wd);
    end
    exp_if = 0; exp_d = 0;
    if (cyc >= next_free) begin
      if (if_pend && d_pend) begin
        if (streak_m == MAXS) exp_if = 1; else exp_d = 1;
      end else if (if_pend) exp_if = 1;
      else if (d_pend) exp_d = 1;
    end
    check("if_gnt", if_gnt, exp_if);
    check("d_gnt", d_gnt, exp_d);
    if (exp_if || exp_d) begin
      lat = $urandom_range(9);
      noack = (lat == 9);
      lat = (lat < 6) ? 1 + $urandom_range(4) : TO;
      t_we = exp_d && dwe;
      t_addr = exp_d ? d_a : if_a;
      t_wd = exp_d ? d_wd : '0;
      busy_lo = cyc + 1; busy_hi = cyc + lat;
      ack_cyc = noack ? -1 : cyc + lat;
      ack_data = $urandom;
      next_free = cyc + lat + 2;
      streak_m = (exp_d && if_pend) ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
      r.is_d = exp_d;
      r.rdata = (noack || t_we) ? '0 : ack_data;
      r.err = noack;
      r.at = cyc + lat + 1;
      sb.push_back(r);
      if (exp_if) if_pend = 0; else d_pend = 0;
    end
  endtask

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].at < cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_rvalid @cyc %0d: got none, expected response at cyc %0d", cyc, e.at);
      end
      if (if_rvalid || d_rvalid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid @cyc %0d: got if=%0b d=%0b, expected none", cyc, if_rvalid, d_rvalid);
        end else begin
          e = sb.pop_front();
          check("rvalid_cycle", cyc, e.at);
          check("rvalid_owner", {if_rvalid, d_rvalid}, e.is_d ? 2'b01 : 2'b10);
          check("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
          check("err", e.is_d ? d_err : if_err, e.err);
          check("other_quiet", e.is_d ? {if_err, if_rdata} : {d_err, d_rdata}, '0);
        end
      end else begin
        check("idle_resp_zero", {if_err, if_rdata, d_err, d_rdata}, '0);
      end
    end
  end

  initial begin
    int tries;
    if_req = 1; d_req = 1; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {if_gnt, d_gnt}, '0);
    check("rst_mem", {mem_req, mem_we, busy}, '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_rvalid", {if_rvalid, d_rvalid}, '0);
    if_req = 0; d_req = 0; mem_ack = 0;
    reset = 1;

    for (int i = 0; i < 1500; i++) step(40, 50, 1);
    for (int i = 0; i < 300; i++) step(100, 100, 0);

    tries = 0;
    do begin step(60, 60, 0); tries++; end
    while (!((cyc >= busy_lo) && (cyc < busy_hi)) && tries < 200);
    if (tries >= 200) begin
      checks++; errors++;
      $display("FAIL mid_reset_setup: got no busy window, expected one within 200 cycles");
    end
    #2 reset = 0;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    if_req = 0; d_req = 0; if_pend = 0; d_pend = 0; mem_ack = 0;
    sb.delete();
    busy_lo = -100; busy_hi = -100; ack_cyc = -1; next_free = 0; streak_m = 0;
    repeat (3) @(negedge clk);
    reset = 1;

    for (int i = 0; i < 20; i++) step(100, 0, 1);
    for (int i = 0; i < 1000; i++) step(50, 50, 1);
    for (int i = 0; i < 200; i++) step(100, 100, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
